// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared constants and types for the hex display slice.
// Page select enum, digit count and the default debounce length.
package hex_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_PAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_e;

  // nibble idx of a 32-bit word
  function automatic logic [3:0] nibble_of(
    input logic [31:0] w,
    input logic [2:0] idx
  );
    logic [31:0] sh;
    sh = w >> {idx, 2'b00};
    return sh[3:0];
  endfunction

endpackage

// File: rtl/hex_display_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counting debouncer.
// press_o is high on the edge where the stable level falls 1->0.
module btn_debounce
  import hex_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic s1, s2, stable;
  logic [CW-1:0] cnt;
  logic accept;

  // counter saturates at CMAX and the level flips there
  assign accept = (s2 != stable) && (cnt == CMAX);
  assign press_o = accept && stable;

  // two-flop synchronizer, idles released (high)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_ni;
      s2 <= s1;
    end
  end

  // stable level and disagreement counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: captures a debug word and pages it onto 6 digits.
// Define HEX_LZB_EN to enable leading-zero blanking.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic        freeze_i,
  input  logic        page_btn_ni,
  output logic [23:0] digit_nibble_o,
  output logic [5:0]  digit_blank_o,
  output logic        page_o,
  output logic        update_o
);

`ifdef HEX_LZB_EN
  localparam logic [5:0] RST_BLANK = 6'b111110;
`else
  localparam logic [5:0] RST_BLANK = 6'b000000;
`endif

  logic [31:0] held;
  logic        cap, cap_q, press;
  page_e       page_q;
  logic [23:0] nib_d;
  logic [5:0]  blank_d;

  assign data_ready_o = ~freeze_i & ~rst_i;
  assign cap = data_valid_i & data_ready_o;
  assign page_o = page_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_ni (page_btn_ni),
    .press_o(press)
  );

  // hold the captured word and remember that a capture happened
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held  <= '0;
      cap_q <= 1'b0;
    end else begin
      cap_q <= cap;
      if (cap) held <= data_i;
    end
  end

  // each debounced press flips the page
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      page_q <= PAGE_LO;
    end else if (press) begin
      page_q <= (page_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
    end
  end

  // per-digit nibble and blank view of the held word
  always_comb begin
    nib_d   = '0;
    blank_d = '0;
    if (page_q == PAGE_LO) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        nib_d[4*k +: 4] = nibble_of(held, 3'(k));
      end
`ifdef HEX_LZB_EN
      begin
        logic seen;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
          seen = seen | (nibble_of(held, 3'(k)) != 4'h0);
          blank_d[k] = ~seen;
        end
      end
`endif
    end else begin
      nib_d[7:0] = held[31:24];
      blank_d    = 6'b111100;
`ifdef HEX_LZB_EN
      blank_d[1] = (held[31:28] == 4'h0);
`endif
    end
  end

  // registered display outputs, one edge behind held/page
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_nibble_o <= '0;
      digit_blank_o  <= RST_BLANK;
      update_o       <= 1'b0;
    end else begin
      digit_nibble_o <= nib_d;
      digit_blank_o  <= blank_d;
      update_o       <= cap_q;
    end
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Feeds the six 7-segment decoder instances on the board from a 32-bit debug word (PC, register value or bus data) exported by the RV32I core. Captures the word through a valid/ready handshake, holds it, and presents one page of nibbles at a time with per-digit blank flags; a debounced push-button toggles between the low page and the high page. Sits between the core's debug export and the per-digit segment decoders.

## Interface
- NUM_DIGITS, 6, number of physical display digits (fixed at 6 for this block)
- DEBOUNCE_CYCLES, 500000, stable cycles required to accept a button level (10 ms at 50 MHz)
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- data_i  input  32  word to display
- data_valid_i  input  1  data_i is valid this cycle
- data_ready_o  output  1  block accepts data_i this cycle
- freeze_i  input  1  hold the current word, refuse new captures
- page_btn_ni  input  1  raw page push-button, active-low, asynchronous to clk_i
- digit_nibble_o  output  24  nibble for digit k on bits [4k+3:4k]
- digit_blank_o  output  6  1 = digit k dark; decoder output is forced off by the top level
- page_o  output  1  0 = nibbles 5..0 shown, 1 = nibbles 7..6 shown
- update_o  output  1  one-cycle pulse when displayed outputs change due to a capture

## Operation
- Handshake: data_ready_o = ~freeze_i, combinational; 0 while rst_i is high. Capture occurs on any edge where data_valid_i && data_ready_o; held word := data_i. Back-to-back captures are allowed every cycle.
- Page 0: digit k shows held[4k+3:4k], k = 0..5.
- Page 1: digit 0 shows held[27:24], digit 1 shows held[31:28]; digits 5..2 are blanked and their nibbles are 0.
- Button path: 2-flop synchronizer, then the debouncer. The debouncer keeps a stable level and a counter. When the synced sample differs from the stable level, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears. Any sample equal to the stable level clears the counter.
- A stable 1->0 transition is a press. A press toggles page_o. Releases are ignored.
- freeze_i does not block page toggles.
- update_o pulses for one cycle coincident with the output registers loading a captured word, including when the captured value equals the held value.
- Simultaneous capture and press: both take effect. The next output update shows the new word on the new page.
- Reset mid-operation: all state returns to its reset value immediately (asynchronous), with no pending capture or press retained.

## Timing
- Reset values:
  - held word 0
  - page_o 0
  - digit_nibble_o 0
  - update_o 0
  - debouncer stable level 1, counter 0, synchronizer flops 1
  - digit_blank_o 6'b111110 when HEX_LZB_EN is defined, else 6'b000000
- All outputs except data_ready_o are registered.
- Capture at edge N: held word updates at N, digit outputs and update_o change at edge N+1.
- Press latency:
  - 2 synchronizer cycles plus DEBOUNCE_CYCLES stable cycles until the stable level flips.
  - page_o toggles on that same edge.
  - Digit outputs reflect the new page one edge later.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps; it clears on accept.

## Configuration
- HEX_LZB_EN defined: leading-zero blanking.
  - Page 0: digits above the most significant nonzero nibble are blanked. Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Page 1: digit 1 is blanked when held[31:28] == 0. Digit 0 is never blanked.
- HEX_LZB_EN undefined: only page-1 digits 5..2 are blanked. All other digits always show.

## Structure
- hex_display_pkg holds:
  - NUM_DIGITS and NUM_PAGES constants
  - page_e typedef (PAGE_LO, PAGE_HI)
  - default DEBOUNCE_CYCLES
- Sub-module btn_debounce contains the synchronizer, stable level, counter and press-pulse output. It is parameterised by DEBOUNCE_CYCLES. The bench overrides it to 4.

## Test plan
- Reset, then release: digit_nibble_o = 0, page_o = 0, digit_blank_o = 6'b111110 (LZB) or 6'b0, data_ready_o = 1.
- Capture 32'hDEADBEEF: one cycle later digit_nibble_o = 24'hADBEEF, update_o pulses once, no digits blanked.
- Press held low 8 cycles (DEBOUNCE_CYCLES = 4): page_o = 1; digit nibbles show D,E on digits 1,0; digit_blank_o = 6'b111100.
- Bounce 3 cycles low then high, repeated: page_o never toggles. Then a clean press toggles it exactly once.
- freeze_i = 1 with data_valid_i = 1 and data_i = 32'h12345678: data_ready_o = 0, displayed value unchanged, no update_o pulse.
- LZB build, capture 32'h00000A05 on page 0: digit_blank_o = 6'b111000. Capture 0: digit_blank_o = 6'b111110 and digit 0 shows 0.
